// File: rtl/tx_channel_arbiter_if.sv
// Packet-stream bundle for tx_channel_arbiter: AW and AR packet inputs, merged tx output, packet counters.
// master = upstream sources plus downstream sink; slave = the arbiter.
interface tx_channel_arbiter_if;
  logic [127:0] aw_channel;
  logic [15:0]  aw_channel_keep;
  logic         aw_channel_last;
  logic [3:0]   aw_channel_connection_id;
  logic [12:0]  aw_channel_byte_num;
  logic         aw_channel_valid;
  logic         aw_channel_ready;

  logic [127:0] ar_channel;
  logic [15:0]  ar_channel_keep;
  logic         ar_channel_last;
  logic [3:0]   ar_channel_connection_id;
  logic [12:0]  ar_channel_byte_num;
  logic         ar_channel_valid;
  logic         ar_channel_ready;

  logic [127:0] tx_data;
  logic [15:0]  tx_keep;
  logic         tx_last;
  logic [3:0]   tx_connection_id;
  logic [12:0]  tx_byte_num;
  logic         tx_src;
  logic         tx_valid;
  logic         tx_ready;

  logic [31:0]  aw_pkt_cnt;
  logic [31:0]  ar_pkt_cnt;

  modport master (
    output aw_channel, aw_channel_keep, aw_channel_last, aw_channel_connection_id,
           aw_channel_byte_num, aw_channel_valid,
    input  aw_channel_ready,
    output ar_channel, ar_channel_keep, ar_channel_last, ar_channel_connection_id,
           ar_channel_byte_num, ar_channel_valid,
    input  ar_channel_ready,
    input  tx_data, tx_keep, tx_last, tx_connection_id, tx_byte_num, tx_src, tx_valid,
    output tx_ready,
    input  aw_pkt_cnt, ar_pkt_cnt
  );

  modport slave (
    input  aw_channel, aw_channel_keep, aw_channel_last, aw_channel_connection_id,
           aw_channel_byte_num, aw_channel_valid,
    output aw_channel_ready,
    input  ar_channel, ar_channel_keep, ar_channel_last, ar_channel_connection_id,
           ar_channel_byte_num, ar_channel_valid,
    output ar_channel_ready,
    output tx_data, tx_keep, tx_last, tx_connection_id, tx_byte_num, tx_src, tx_valid,
    input  tx_ready,
    output aw_pkt_cnt, ar_pkt_cnt
  );
endinterface

// File: rtl/tx_channel_arbiter.sv
// Packet-granular two-channel arbiter (AW/AR) merging into one registered tx stream.
// Define TX_ARB_PKT_CNT_EN to build the per-channel completed-packet counters.
module tx_channel_arbiter #(
  parameter int MAX_RUN = 4
) (
  input logic              clk,
  input logic              resetn,
  tx_channel_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, AW_PKT, AR_PKT} state_t;

  localparam logic [3:0] RUN_LIMIT = 4'(MAX_RUN);

  state_t       state;
  logic         ptr;
  logic         last_src;
  logic [3:0]   run_cnt;
  logic         rdy_en;

  logic         tx_free;
  logic         win;
  logic         grant_aw;
  logic         grant_ar;
  logic         rdy_aw;
  logic         rdy_ar;
  logic         acc_aw_p0;
  logic         acc_ar_p0;
  logic         vld_p0;
  logic         src_p0;
  logic         last_p0;
  logic [127:0] data_p0;
  logic [15:0]  keep_p0;
  logic [3:0]   id_p0;
  logic [12:0]  bytes_p0;

  // Stage p0: grant, handshake and source select, all resolved combinationally
  always_comb begin
    tx_free = !bus.tx_valid || bus.tx_ready;
    if (bus.aw_channel_valid && bus.ar_channel_valid)
      win = (run_cnt >= RUN_LIMIT) ? ~last_src : ptr;
    else
      win = bus.ar_channel_valid;

    grant_aw = 1'b0;
    grant_ar = 1'b0;
    case (state)
      IDLE:    begin grant_aw = ~win; grant_ar = win; end
      AW_PKT:  grant_aw = 1'b1;
      AR_PKT:  grant_ar = 1'b1;
      default: ;
    endcase

    // rdy_en keeps both readys low until the first edge after reset release
    rdy_aw    = rdy_en && grant_aw && tx_free;
    rdy_ar    = rdy_en && grant_ar && tx_free;
    acc_aw_p0 = rdy_aw && bus.aw_channel_valid;
    acc_ar_p0 = rdy_ar && bus.ar_channel_valid;
    vld_p0    = acc_aw_p0 || acc_ar_p0;
    src_p0    = acc_ar_p0;

    if (acc_ar_p0) begin
      last_p0  = bus.ar_channel_last;
      data_p0  = bus.ar_channel;
      keep_p0  = bus.ar_channel_keep;
      id_p0    = bus.ar_channel_connection_id;
      bytes_p0 = bus.ar_channel_byte_num;
    end else begin
      last_p0  = bus.aw_channel_last;
      data_p0  = bus.aw_channel;
      keep_p0  = bus.aw_channel_keep;
      id_p0    = bus.aw_channel_connection_id;
      bytes_p0 = bus.aw_channel_byte_num;
    end
  end

  assign bus.aw_channel_ready = rdy_aw;
  assign bus.ar_channel_ready = rdy_ar;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) rdy_en <= 1'b0;
    else         rdy_en <= 1'b1;
  end

  // Stage p1: output register, loaded on acceptance and held while stalled
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bus.tx_valid         <= 1'b0;
      bus.tx_data          <= '0;
      bus.tx_keep          <= '0;
      bus.tx_last          <= 1'b0;
      bus.tx_connection_id <= '0;
      bus.tx_byte_num      <= '0;
      bus.tx_src           <= 1'b0;
    end else if (vld_p0) begin
      bus.tx_valid         <= 1'b1;
      bus.tx_data          <= data_p0;
      bus.tx_keep          <= keep_p0;
      bus.tx_last          <= last_p0;
      bus.tx_connection_id <= id_p0;
      bus.tx_byte_num      <= bytes_p0;
      bus.tx_src           <= src_p0;
    end else if (bus.tx_ready) begin
      bus.tx_valid         <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      ptr      <= 1'b0;
      last_src <= 1'b0;
      run_cnt  <= '0;
    end else begin
      case (state)
        IDLE:          if (vld_p0 && !last_p0) state <= src_p0 ? AR_PKT : AW_PKT;
        AW_PKT, AR_PKT: if (vld_p0 && last_p0) state <= IDLE;
        default:       state <= IDLE;
      endcase
      if (vld_p0 && last_p0) begin
        ptr      <= ~src_p0;
        last_src <= src_p0;
        if (src_p0 != last_src)  run_cnt <= 4'd1;
        else if (run_cnt != 4'hF) run_cnt <= run_cnt + 4'd1;
      end
    end
  end

`ifdef TX_ARB_PKT_CNT_EN
  logic [31:0] aw_cnt_q;
  logic [31:0] ar_cnt_q;

  // Counts completed packets as they leave the output register; wraps naturally
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      aw_cnt_q <= '0;
      ar_cnt_q <= '0;
    end else if (bus.tx_valid && bus.tx_ready && bus.tx_last) begin
      if (bus.tx_src) ar_cnt_q <= ar_cnt_q + 32'd1;
      else            aw_cnt_q <= aw_cnt_q + 32'd1;
    end
  end

  assign bus.aw_pkt_cnt = aw_cnt_q;
  assign bus.ar_pkt_cnt = ar_cnt_q;
`else
  assign bus.aw_pkt_cnt = '0;
  assign bus.ar_pkt_cnt = '0;
`endif

endmodule
